reg_wr_ctrl: RTL and testbench

REG_WR_CTRL -- requirements
Module: reg_wr_ctrl

---
 rtl/reg_wr_pkg.sv | 18 +
 rtl/reg_wr_ctrl_if.sv | 22 ++
 rtl/reg_wr_timer.sv | 36 +++
 rtl/reg_wr_ctrl.sv | 157 +++++++++++++++
 tb/tb_reg_wr_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_wr_pkg.sv
// Shared types and constants for the framed register-write controller.
package reg_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHK   = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam logic [3:0] SYNC        = 4'hA;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SYNC    = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/reg_wr_ctrl_if.sv
// Byte stream in, register-bank write port and status out.
interface reg_wr_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        write_en;
  logic [3:0]  add_line;
  logic [31:0] wr_data;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  frame_cnt;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, write_en, add_line, wr_data, err, err_code, frame_cnt
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, write_en, add_line, wr_data, err, err_code, frame_cnt
  );
endinterface

// File: rtl/reg_wr_timer.sv
// Inter-byte idle counter; expired fires on the cycle the count would reach TIMEOUT.
module reg_wr_timer #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  // clear has priority so an accepted byte always restarts the idle window
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // run is low when a byte is accepted, so a byte on the limit cycle wins
  assign expired = run && (cnt_q == TIMEOUT - 8'd1);

endmodule

// File: rtl/reg_wr_ctrl.sv
// Receives 6-byte frames (header, D3..D0, XOR checksum) and issues one
// register-bank write per good frame.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | waiting for a header byte with the sync nibble
//   ST_DATA  | shifting in the four data bytes, MSB first
//   ST_CHK   | comparing the checksum byte to the running XOR
//   ST_WRITE | single write_en cycle, input stalled
module reg_wr_ctrl
  import reg_wr_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic         clk,
  input  logic         reset_n,
  reg_wr_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [7:0]  xor_q, xor_d;
  logic [3:0]  addr_q, addr_d;
  logic        write_en_q, write_en_d;
  logic [3:0]  add_line_q, add_line_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic accept;
  logic tmr_clear;
  logic tmr_run;
  logic tmr_expired;

  assign bus.rx_ready = reset_n && (state_q != ST_WRITE);
  assign accept       = bus.rx_valid && bus.rx_ready;

  assign tmr_clear = accept || (state_q == ST_IDLE) || (state_q == ST_WRITE);
  assign tmr_run   = ((state_q == ST_DATA) || (state_q == ST_CHK)) && !accept;

  reg_wr_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .run     (tmr_run),
    .expired (tmr_expired)
  );

  // next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    xor_d       = xor_q;
    addr_d      = addr_q;
    write_en_d  = 1'b0;
    add_line_d  = add_line_q;
    wr_data_d   = wr_data_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.rx_data[7:4] == SYNC) begin
            addr_d     = bus.rx_data[3:0];
            xor_d      = bus.rx_data;
            byte_cnt_d = 2'd0;
            state_d    = ST_DATA;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_SYNC;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          shift_d    = {shift_q[23:0], bus.rx_data};
          xor_d      = xor_q ^ bus.rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = ST_CHK;
          end
        end else if (tmr_expired) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_IDLE;
        end
      end
      ST_CHK: begin
        if (accept) begin
          if (bus.rx_data == xor_q) begin
            write_en_d  = 1'b1;
            add_line_d  = addr_q;
            wr_data_d   = shift_q;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = ST_WRITE;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = ST_IDLE;
          end
        end else if (tmr_expired) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      xor_q       <= '0;
      addr_q      <= '0;
      write_en_q  <= 1'b0;
      add_line_q  <= '0;
      wr_data_q   <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      xor_q       <= xor_d;
      addr_q      <= addr_d;
      write_en_q  <= write_en_d;
      add_line_q  <= add_line_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.write_en  = write_en_q;
  assign bus.add_line  = add_line_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_reg_wr_ctrl.sv
// Scoreboard bench for reg_wr_ctrl: expected writes/errors queued as frames
// are driven, popped by a negedge monitor when the DUT strobes them.
module tb_reg_wr_ctrl;
  import reg_wr_pkg::*;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
    logic [7:0]  c;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int err4_n = 0;

  wr_t        wr_q[$];
  logic [1:0] errq[$];
  wr_t        mon_e;
  logic [7:0] exp_cnt = 8'd0;
  logic [3:0] last_a = 4'd0;
  logic [31:0] last_d = 32'd0;

  reg_wr_ctrl_if bus ();
  reg_wr_ctrl_if bus4 ();

  reg_wr_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  reg_wr_ctrl #(.TIMEOUT(8'd4)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] fcs(input logic [3:0] a, input logic [31:0] d);
    logic [7:0] h;
    h = {4'hA, a};
    return h ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  // monitor: handshake rule plus scoreboard pops
  always @(negedge clk) begin
    if (reset_n) begin
      chk("rdy_vs_write", bus.rx_ready, !bus.write_en);
      if (bus.write_en) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          mon_e = wr_q.pop_front();
          chk("wr_addr", bus.add_line, mon_e.a);
          chk("wr_data", bus.wr_data, mon_e.d);
          chk("wr_cnt", bus.frame_cnt, mon_e.c);
        end
      end
      if (bus.err) begin
        if (errq.size() == 0) chk("unexpected_err", bus.err_code, 0);
        else chk("err_code", bus.err_code, errq.pop_front());
      end
    end else begin
      chk("rdy_in_reset", bus.rx_ready, 0);
    end
  end

  always @(negedge clk) if (reset_n && bus4.err) err4_n++;

  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clk);
      if (bus.rx_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] a, input logic [31:0] d, input logic [7:0] c);
    wr_t e;
    if (c == fcs(a, d)) begin
      exp_cnt++;
      e.a = a; e.d = d; e.c = exp_cnt;
      wr_q.push_back(e);
      last_a = a;
      last_d = d;
    end else begin
      errq.push_back(ERR_CHK);
    end
    send_byte({4'hA, a});
    send_byte(d[31:24]);
    send_byte(d[23:16]);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    send_byte(c);
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_write_en", bus.write_en, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_err_code", bus.err_code, 0);
    chk("rst_add_line", bus.add_line, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_frame_cnt", bus.frame_cnt, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_cnt = 8'd0;
    last_a = 4'd0;
    last_d = 32'd0;
  endtask

  task automatic drv4(input logic [7:0] b);
    bus4.rx_valid = 1'b1;
    bus4.rx_data  = b;
    @(posedge clk);
    #1;
    bus4.rx_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus4.rx_valid = 1'b0;
    bus4.rx_data  = 8'h00;
    @(posedge clk);
    #1;
    do_reset();

    // TIMEOUT=4: byte on the limit cycle wins, then a real timeout
    drv4(8'hA0);
    drv4(8'h11);
    repeat (3) @(posedge clk);
    #1;
    drv4(8'h22);
    drv4(8'h33);
    drv4(8'h44);
    drv4(8'hE4);
    @(negedge clk);
    chk("t4_write_en", bus4.write_en, 1);
    chk("t4_wr_data", bus4.wr_data, 32'h11223344);
    chk("t4_no_err", err4_n, 0);
    @(posedge clk);
    #1;
    drv4(8'hA0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_err_early", err4_n, 0);
    @(posedge clk);
    #1;
    chk("t4_err", bus4.err, 1);
    chk("t4_err_code", bus4.err_code, ERR_TIMEOUT);

    // good frame A3 12 34 56 78 AB
    send_frame(4'h3, 32'h12345678, 8'hAB);
    idle(3);

    // bad sync then a valid frame
    errq.push_back(ERR_SYNC);
    send_byte(8'h53);
    idle(2);
    send_frame(4'h7, 32'hDEADBEEF, fcs(4'h7, 32'hDEADBEEF));
    idle(2);

    // bad checksum leaves outputs alone and holds err_code
    send_frame(4'hF, 32'h00000001, 8'h00);
    idle(4);
    chk("badchk_add_line", bus.add_line, last_a);
    chk("badchk_wr_data", bus.wr_data, last_d);
    chk("err_code_hold", bus.err_code, ERR_CHK);

    // timeout after A0 11 with TIMEOUT=255
    errq.push_back(ERR_TIMEOUT);
    send_byte(8'hA0);
    send_byte(8'h11);
    bus.rx_valid = 1'b0;
    repeat (255) @(negedge clk);
    #1;
    chk("to_not_early", errq.size(), 1);
    @(negedge clk);
    #1;
    chk("to_fired", errq.size(), 0);
    idle(2);
    send_frame(4'h9, 32'hCAFEF00D, fcs(4'h9, 32'hCAFEF00D));
    idle(2);

    // reset mid-frame then address 5
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    do_reset();
    send_frame(4'h5, 32'h0BADC0DE, fcs(4'h5, 32'h0BADC0DE));
    idle(2);
    chk("a5_add_line", bus.add_line, 4'h5);
    chk("a5_wr_data", bus.wr_data, 32'h0BADC0DE);

    // 256 back-to-back frames, frame_cnt wraps
    do_reset();
    for (int k = 0; k < 256; k++) begin
      rd = $urandom;
      send_frame(k[3:0], rd, fcs(k[3:0], rd));
    end
    idle(4);
    chk("wrap_frame_cnt", bus.frame_cnt, 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("err_q_empty", errq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
